// File: rtl/nibble_serial_cmp_ctrl_pkg.sv
// Shared encodings for the serial nibble comparator: FSM states and result codes.
// Pure definitions, no logic.
package cmp_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  function automatic logic [1:0] res_code(input logic gt, input logic lt);
    return gt ? RES_GT : (lt ? RES_LT : RES_EQ);
  endfunction

endpackage

// File: rtl/nibble_serial_cmp_ctrl_nibble_cmp.sv
// Combinational 4-bit unsigned magnitude comparator; zero latency.
// No handshake, pure function of its inputs.
module nibble_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/nibble_serial_cmp_ctrl.sv
// Serial wide-operand compare over one shared nibble comparator, MSB nibble first.
// Latency NIBBLES+1 from accept to done (k+1 on first difference when EARLY_EXIT_EN is defined).
// start is ignored while busy; start in the DONE cycle is accepted back-to-back.
module nibble_serial_cmp_ctrl
  import cmp_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 a_gt_b,
  output logic                 a_lt_b,
  output logic                 a_eq_b
);

  localparam int IW = $clog2(NIBBLES);

  logic [1:0]           state;
  logic [4*NIBBLES-1:0] op_a;
  logic [4*NIBBLES-1:0] op_b;
  logic [IW-1:0]        idx;
  logic                 decided;
  logic [1:0]           pend_res;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic       n_gt;
  logic       n_lt;
  logic       n_eq;

  logic [1:0] cur_res;
  logic [1:0] fin_res;
  logic       exit_now;

  assign nib_a = op_a[4*int'(idx) +: 4];
  assign nib_b = op_b[4*int'(idx) +: 4];

  nibble_cmp u_nibble_cmp (
    .a  (nib_a),
    .b  (nib_b),
    .gt (n_gt),
    .lt (n_lt),
    .eq (n_eq)
  );

  // A decision already latched wins; otherwise the nibble under test decides.
  always_comb begin
    cur_res = res_code(n_gt, n_lt);
    fin_res = decided ? pend_res : cur_res;
`ifdef EARLY_EXIT_EN
    exit_now = (idx == '0) || (!decided && !n_eq);
`else
    exit_now = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_gt_b   <= 1'b0;
      a_lt_b   <= 1'b0;
      a_eq_b   <= 1'b0;
      idx      <= '0;
      decided  <= 1'b0;
      pend_res <= RES_EQ;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_a     <= a;
            op_b     <= b;
            idx      <= IW'(NIBBLES - 1);
            decided  <= 1'b0;
            pend_res <= RES_EQ;
            busy     <= 1'b1;
            state    <= ST_CMP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CMP: begin
          if (!decided && !n_eq) begin
            decided  <= 1'b1;
            pend_res <= cur_res;
          end
          // Exit happens at idx==0 before any decrement, so idx never wraps.
          if (exit_now) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            a_gt_b <= (fin_res == RES_GT);
            a_lt_b <= (fin_res == RES_LT);
            a_eq_b <= (fin_res == RES_EQ);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_cmp_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks done/busy/flags.
// Reference model uses plain unsigned arithmetic on whole operands.
module tb_nibble_serial_cmp_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [2:0] flags;   // {gt, lt, eq}
    int         x;       // accept edge number
    int         lat;     // expected accept-to-done latency in cycles
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         a_gt_b;
  logic         a_lt_b;
  logic         a_eq_b;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         next_free = 0;
  logic [2:0] held = 3'b000;
  exp_t       q[$];

  nibble_serial_cmp_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_flags(input logic [W-1:0] av, input logic [W-1:0] bv);
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef EARLY_EXIT_EN
    for (int k = 1; k <= N; k++)
      if (av[4*(N-k) +: 4] != bv[4*(N-k) +: 4]) return k + 1;
`endif
    return N + 1;
  endfunction

  // Present start for one cycle (left high on return); accepted only once the previous compare is done.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   x;
    start = 1'b1;
    a = av;
    b = bv;
    x = cyc + 1;
    if (x >= next_free) begin
      e.flags = exp_flags(av, bv);
      e.x = x;
      e.lat = exp_lat(av, bv);
      next_free = x + e.lat;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy;
      exp_busy = (q.size() > 0) && (cyc >= q[0].x) && (cyc < q[0].x + q[0].lat - 1);
      check("busy", 32'(busy), 32'(exp_busy));
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          check("latency", 32'(cyc - q[0].x + 1), 32'(q[0].lat));
          check("flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(q[0].flags));
          held = q[0].flags;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].x + q[0].lat - 1) begin
        check("missed_done", 32'(done), 32'd1);
        void'(q.pop_front());
      end
      check("flags_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'(held));
    end
  end

  initial begin
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] one;
    one = 1;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive_start(16'h1234, 16'h1234); idle(7);
    drive_start(16'h8000, 16'h7FFF); idle(7);
    drive_start(16'h12F4, 16'h12F5); idle(7);

    // start during CMP with different operands must be ignored
    drive_start(16'h0001, 16'h0000); idle(1);
    drive_start(16'h0000, 16'hFFFF); idle(7);

    // reset during the second CMP cycle aborts the compare
    drive_start(16'h1234, 16'h1235);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    next_free = 0;
    held = 3'b000;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_gt", 32'(a_gt_b), 32'd0);
    check("abort_lt", 32'(a_lt_b), 32'd0);
    check("abort_eq", 32'(a_eq_b), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    drive_start(16'hBEEF, 16'hBEEF); idle(7);

    // start held high through DONE: back-to-back accept without IDLE
    drive_start(16'h1111, 16'h2222);
    repeat (N + 1) drive_start(16'h00FF, 16'h0100);
    idle(8);

    for (int t = 0; t < 40; t++) begin
      av = W'($urandom);
      bv = av;
      case ($urandom_range(0, 3))
        0: bv = av;
        1: bv = av ^ (one << $urandom_range(0, W - 1));
        default: bv = W'($urandom);
      endcase
      drive_start(av, bv);
      idle($urandom_range(0, N + 2));
    end

    idle(1);
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
